cr_isf_debug_trig: RTL and testbench

Debug trigger and single-step engine on the ISF ingress data path, directly downstream of the ISF register file. It consumes the trigger configuration and the `single_step_rd` pulse that the register file produces. It returns the capture and status values that the register file exposes on the rbus. It watches every word transferred on the 64-bit ingress stream and captures the first word that matches the programmed TLV type and data pattern. Optionally, it then stalls the stream and releases exactly one word per single-step request, capturing each released word.

---
 rtl/cr_isf_debug_trig_if.sv | 34 +++
 rtl/cr_isf_debug_trig.sv | 172 +++++++++++++++++
 tb/tb_cr_isf_debug_trig.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_isf_debug_trig_if.sv
// ISF ingress stream bundle seen by the debug trigger engine.
//
// Handshake: a word moves across a hop in any cycle where its valid and
// ready are both high. Once valid is raised, the source holds valid, data
// and the sot/eot markers stable until that cycle; ready may change freely
// and carries no promise about future cycles.
//
// The in_* group is the upstream hop and the ds_* group is the downstream
// hop. The engine sits between them with no storage.
interface cr_isf_debug_trig_if;
  logic        in_vld;
  logic [63:0] in_data;
  logic        in_sot;
  logic        in_eot;
  logic        in_rdy;

  logic        ds_vld;
  logic [63:0] ds_data;
  logic        ds_sot;
  logic        ds_eot;
  logic        ds_rdy;

  // Environment side: upstream source plus downstream sink.
  modport master (
    output in_vld, in_data, in_sot, in_eot, ds_rdy,
    input  in_rdy, ds_vld, ds_data, ds_sot, ds_eot
  );

  // Engine side.
  modport slave (
    input  in_vld, in_data, in_sot, in_eot, ds_rdy,
    output in_rdy, ds_vld, ds_data, ds_sot, ds_eot
  );
endinterface

// File: rtl/cr_isf_debug_trig.sv
// Debug trigger and single-step engine on the ISF ingress data path.
// Watches every word that transfers, captures the first one matching the
// programmed TLV type and masked data pattern, and can then hold the stream
// and release exactly one word per single-step request. Data and markers are
// never registered in the path; only ready/valid are gated by the stall.
module cr_isf_debug_trig #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,

  cr_isf_debug_trig_if.slave st,

  input  logic               trig_en,
  input  logic               ss_en,
  input  logic               arm_stb,
  input  logic               tlv_chk_en,
  input  logic [7:0]         trig_tlv_type,
  input  logic [31:0]        match_lo,
  input  logic [31:0]        match_hi,
  input  logic [31:0]        mask_lo,
  input  logic [31:0]        mask_hi,
  input  logic               single_step_rd,

  output logic [31:0]        trig_cap_lo,
  output logic [31:0]        trig_cap_hi,
  output logic [31:0]        ss_cap_lo,
  output logic [31:0]        ss_cap_hi,
  output logic [7:0]         ss_cap_sb,
  output logic [2:0]         stat_state,
  output logic [7:0]         stat_trig_cnt,
  output logic [CNT_W-1:0]   stat_ss_cnt,
  output logic               stall
);

  // State encodings are visible to software through stat_state.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_STALL = 3'd3,
    S_STEP  = 3'd4
  } state_t;

  state_t             state_q;
  logic [7:0]         cur_type_q;
  logic [63:0]        trig_cap_q;
  logic [63:0]        ss_cap_q;
  logic               ss_sot_q;
  logic               ss_eot_q;
  logic [7:0]         trig_cnt_q;
  logic [CNT_W-1:0]   ss_cnt_q;

  logic               xfer;
  logic [7:0]         word_type;
  logic               pat_ok;
  logic               type_ok;
  logic               hit;
  logic [63:0]        match_w;
  logic [63:0]        mask_w;

  // Stall is a pure decode of the state register so it drops together with
  // an asynchronous reset and never glitches on input changes.
  assign stall = (state_q == S_STALL);

  // Combinational gating of the stream; data and markers pass straight through.
  assign st.in_rdy  = st.ds_rdy & ~stall;
  assign st.ds_vld  = st.in_vld & ~stall;
  assign st.ds_data = st.in_data;
  assign st.ds_sot  = st.in_sot;
  assign st.ds_eot  = st.in_eot;

  assign xfer = st.in_vld & st.in_rdy;

  // Trigger match: masked data compare plus optional TLV type compare. The
  // type of a start-of-TLV word is its own low byte; later words inherit the
  // type latched from the most recent start word.
  assign match_w   = {match_hi, match_lo};
  assign mask_w    = {mask_hi, mask_lo};
  assign word_type = st.in_sot ? st.in_data[7:0] : cur_type_q;
  assign pat_ok    = ((st.in_data ^ match_w) & mask_w) == 64'd0;
  assign type_ok   = ~tlv_chk_en | (word_type == trig_tlv_type);
  assign hit       = xfer & pat_ok & type_ok;

  // Track the TLV type of the packet currently flowing, independent of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_type_q <= 8'd0;
    end else if (xfer && st.in_sot) begin
      cur_type_q <= st.in_data[7:0];
    end
  end

  // Trigger/single-step FSM with its captures and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      trig_cap_q <= 64'd0;
      ss_cap_q   <= 64'd0;
      ss_sot_q   <= 1'b0;
      ss_eot_q   <= 1'b0;
      trig_cnt_q <= 8'd0;
      ss_cnt_q   <= '0;
    end else if (!trig_en) begin
      // Disable wins over everything, including a same-cycle arm.
      state_q <= S_IDLE;
    end else if (arm_stb) begin
      // Arming restarts the step count but keeps captures and trigger count
      // so software can still read the previous session. It also beats a
      // same-cycle hit: the word in flight during the arm write is not eligible.
      state_q  <= S_ARMED;
      ss_cnt_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q <= S_IDLE;
        end

        S_ARMED: begin
          if (hit) begin
            trig_cap_q <= st.in_data;
            if (trig_cnt_q != 8'hFF) begin
              trig_cnt_q <= trig_cnt_q + 8'd1;
            end
            state_q <= ss_en ? S_STALL : S_RUN;
          end
        end

        S_RUN: begin
          // One trigger per arm; pass-through until software re-arms.
          state_q <= S_RUN;
        end

        S_STALL: begin
          // Dropping single-step mode lets the stream run freely.
          if (!ss_en) begin
            state_q <= S_RUN;
          end else if (single_step_rd) begin
            state_q <= S_STEP;
          end
        end

        S_STEP: begin
          // Wait as long as needed for exactly one transfer; further step
          // requests arriving here are ignored rather than queued.
          if (xfer) begin
            ss_cap_q <= st.in_data;
            ss_sot_q <= st.in_sot;
            ss_eot_q <= st.in_eot;
            ss_cnt_q <= ss_cnt_q + CNT_W'(1);
            state_q  <= S_STALL;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Status and capture views for the register file.
  assign trig_cap_lo   = trig_cap_q[31:0];
  assign trig_cap_hi   = trig_cap_q[63:32];
  assign ss_cap_lo     = ss_cap_q[31:0];
  assign ss_cap_hi     = ss_cap_q[63:32];
  assign ss_cap_sb     = {6'b0, ss_sot_q, ss_eot_q};
  assign stat_state    = state_q;
  assign stat_trig_cnt = trig_cnt_q;
  assign stat_ss_cnt   = ss_cnt_q;

endmodule

// File: tb/tb_cr_isf_debug_trig.sv
// Self-checking bench for cr_isf_debug_trig: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the engine.
module tb_cr_isf_debug_trig;
  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cr_isf_debug_trig_if st_if ();

  logic              trig_en = 1'b0;
  logic              ss_en = 1'b0;
  logic              arm_stb = 1'b0;
  logic              tlv_chk_en = 1'b0;
  logic [7:0]        trig_tlv_type = 8'd0;
  logic [31:0]       match_lo = 32'd0;
  logic [31:0]       match_hi = 32'd0;
  logic [31:0]       mask_lo = 32'd0;
  logic [31:0]       mask_hi = 32'd0;
  logic              single_step_rd = 1'b0;
  logic [31:0]       trig_cap_lo, trig_cap_hi, ss_cap_lo, ss_cap_hi;
  logic [7:0]        ss_cap_sb;
  logic [2:0]        stat_state;
  logic [7:0]        stat_trig_cnt;
  logic [CNT_W-1:0]  stat_ss_cnt;
  logic              stall;

  cr_isf_debug_trig #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .st             (st_if),
    .trig_en        (trig_en),
    .ss_en          (ss_en),
    .arm_stb        (arm_stb),
    .tlv_chk_en     (tlv_chk_en),
    .trig_tlv_type  (trig_tlv_type),
    .match_lo       (match_lo),
    .match_hi       (match_hi),
    .mask_lo        (mask_lo),
    .mask_hi        (mask_hi),
    .single_step_rd (single_step_rd),
    .trig_cap_lo    (trig_cap_lo),
    .trig_cap_hi    (trig_cap_hi),
    .ss_cap_lo      (ss_cap_lo),
    .ss_cap_hi      (ss_cap_hi),
    .ss_cap_sb      (ss_cap_sb),
    .stat_state     (stat_state),
    .stat_trig_cnt  (stat_trig_cnt),
    .stat_ss_cnt    (stat_ss_cnt),
    .stall          (stall)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int failures = 0;

  // Words still to be offered upstream, in order: {sot, eot, data}.
  logic [65:0] exp_q[$];
  bit  vld_hold = 1'b0;
  int  gap_pct = 0;
  int  rdy_mode = 0;     // 0: always ready, 1: random, 2: toggling
  bit  rdy_tog = 1'b0;
  int  n_deliv = 0;

  // Behavioural view of the engine: what it is currently doing.
  bit          m_armed, m_stepping, m_release, m_ran;
  logic [7:0]  m_cur_type;
  logic [63:0] m_trig_cap, m_ss_cap;
  logic [1:0]  m_ss_sb;
  int          m_trig_cnt;
  logic [CNT_W-1:0] m_ss_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_stepping = 0; m_release = 0; m_ran = 0;
    m_cur_type = 8'd0; m_trig_cap = 64'd0; m_ss_cap = 64'd0; m_ss_sb = 2'd0;
    m_trig_cnt = 0; m_ss_cnt = '0;
  endtask

  function automatic int m_state_code();
    if (m_armed) return 1;
    if (m_stepping) return m_release ? 4 : 3;
    if (m_ran) return 2;
    return 0;
  endfunction

  task automatic check_outputs(input string pfx);
    check_eq({pfx, "state"}, 64'(stat_state), 64'(m_state_code()));
    check_eq({pfx, "stall"}, 64'(stall), 64'(m_stepping && !m_release));
    check_eq({pfx, "trig_cap"}, {trig_cap_hi, trig_cap_lo}, m_trig_cap);
    check_eq({pfx, "trig_cnt"}, 64'(stat_trig_cnt), 64'(m_trig_cnt));
    check_eq({pfx, "ss_cap"}, {ss_cap_hi, ss_cap_lo}, m_ss_cap);
    check_eq({pfx, "ss_sb"}, 64'(ss_cap_sb), 64'(m_ss_sb));
    check_eq({pfx, "ss_cnt"}, 64'(stat_ss_cnt), 64'(m_ss_cnt));
  endtask

  task automatic push_word(input logic [63:0] d, input bit sot, input bit eot);
    exp_q.push_back({sot, eot, d});
  endtask

  // ---------------- driver: one clock of stimulus + model step ----------------
  task automatic do_cycle();
    bit vld, sot, eot, xfer, exp_stall, hit, match;
    logic [63:0] data;
    logic [7:0]  typ;
    vld = (exp_q.size() > 0) && (vld_hold || ($urandom_range(0, 99) >= 32'(gap_pct)));
    if (vld) begin
      {sot, eot, data} = exp_q[0];
    end else begin
      data = {$urandom, $urandom};
      sot  = 1'($urandom_range(0, 1));
      eot  = 1'($urandom_range(0, 1));
    end
    st_if.in_vld  = vld;
    st_if.in_data = data;
    st_if.in_sot  = sot;
    st_if.in_eot  = eot;
    case (rdy_mode)
      0: st_if.ds_rdy = 1'b1;
      1: st_if.ds_rdy = 1'($urandom_range(0, 1));
      default: begin
        rdy_tog = ~rdy_tog;
        st_if.ds_rdy = rdy_tog;
      end
    endcase
    #1;
    exp_stall = m_stepping && !m_release;
    check_eq("in_rdy", 64'(st_if.in_rdy), 64'(st_if.ds_rdy && !exp_stall));
    check_eq("ds_vld", 64'(st_if.ds_vld), 64'(vld && !exp_stall));
    if (vld) begin
      check_eq("ds_data", st_if.ds_data, data);
      check_eq("ds_marks", 64'({st_if.ds_sot, st_if.ds_eot}), 64'({sot, eot}));
    end
    xfer  = vld && st_if.ds_rdy && !exp_stall;
    typ   = sot ? data[7:0] : m_cur_type;
    match = (((data ^ {match_hi, match_lo}) & {mask_hi, mask_lo}) == 64'd0) &&
            (!tlv_chk_en || typ == trig_tlv_type);
    hit   = xfer && match;
    if (xfer) begin
      n_deliv++;
      void'(exp_q.pop_front());
      if (sot) m_cur_type = data[7:0];
    end
    vld_hold = vld && !xfer;
    if (!trig_en) begin
      m_armed = 0; m_stepping = 0; m_release = 0; m_ran = 0;
    end else if (arm_stb) begin
      m_armed = 1; m_stepping = 0; m_release = 0; m_ran = 0;
      m_ss_cnt = '0;
    end else if (m_armed) begin
      if (hit) begin
        m_trig_cap = data;
        if (m_trig_cnt < 255) m_trig_cnt++;
        m_armed = 0;
        if (ss_en) m_stepping = 1;
        else m_ran = 1;
      end
    end else if (m_stepping && !m_release) begin
      if (!ss_en) begin
        m_stepping = 0; m_ran = 1;
      end else if (single_step_rd) begin
        m_release = 1;
      end
    end else if (m_stepping && m_release && xfer) begin
      m_ss_cap = data;
      m_ss_sb  = {sot, eot};
      m_ss_cnt = m_ss_cnt + 1'b1;
      m_release = 0;
    end
    @(posedge clk);
    #1;
    arm_stb = 1'b0;
    single_step_rd = 1'b0;
    check_outputs("");
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic drain(input int limit, input string tag);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < limit) begin
      do_cycle();
      k++;
    end
    check_eq({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic arm();
    arm_stb = 1'b1;
    do_cycle();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    st_if.in_vld = 1'b0; st_if.in_data = 64'd0; st_if.in_sot = 1'b0;
    st_if.in_eot = 1'b0; st_if.ds_rdy = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_state", 64'(stat_state), 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_trig_cnt", 64'(stat_trig_cnt), 64'd0);
    check_eq("rst_ss_cnt", 64'(stat_ss_cnt), 64'd0);
    check_eq("rst_caps", {trig_cap_hi, trig_cap_lo, ss_cap_hi, ss_cap_lo} == 128'd0 ? 64'd0 : 64'd1, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // S1: free-running trigger on the first word after arming.
    trig_en = 1; ss_en = 0; tlv_chk_en = 0; mask_lo = 0; mask_hi = 0;
    match_lo = $urandom; match_hi = $urandom;
    arm();
    base = n_deliv;
    push_word(64'h1111_0000_0000_0001, 1, 0);
    push_word(64'h1111_0000_0000_0002, 0, 0);
    push_word(64'h1111_0000_0000_0003, 0, 1);
    drain(20, "s1");
    check_eq("s1_trig_cap", {trig_cap_hi, trig_cap_lo}, 64'h1111_0000_0000_0001);
    check_eq("s1_trig_cnt", 64'(stat_trig_cnt), 64'd1);
    check_eq("s1_state", 64'(stat_state), 64'd2);
    check_eq("s1_stall", 64'(stall), 64'd0);
    check_eq("s1_deliv", 64'(n_deliv - base), 64'd3);

    // S2: TLV type filter; the pattern inside the wrong TLV is ignored.
    tlv_chk_en = 1; trig_tlv_type = 8'h05;
    match_lo = 32'hDEAD_BEEF; match_hi = 32'd0; mask_lo = 32'hFFFF_FFFF; mask_hi = 32'd0;
    arm();
    push_word(64'h0000_0000_0000_0004, 1, 0);
    push_word(64'h0000_0044_DEAD_BEEF, 0, 0);
    push_word(64'h0000_0000_1234_5604, 0, 1);
    push_word(64'h0000_0000_0000_0005, 1, 0);
    push_word(64'h0000_0055_DEAD_BEEF, 0, 0);
    push_word(64'h0000_0066_DEAD_BEEF, 0, 1);
    drain(20, "s2");
    check_eq("s2_trig_cap", {trig_cap_hi, trig_cap_lo}, 64'h0000_0055_DEAD_BEEF);
    check_eq("s2_trig_cnt", 64'(stat_trig_cnt), 64'd2);

    // S3: trigger then three single steps with a toggling downstream ready.
    tlv_chk_en = 0; mask_lo = 0; mask_hi = 0; ss_en = 1; rdy_mode = 2;
    arm();
    base = n_deliv;
    for (int i = 0; i < 6; i++)
      push_word({32'h3333_0000 + 32'(i), 32'h0000_0A00 + 32'(i)}, (i == 0 || i == 4), (i == 3 || i == 5));
    run_cycles(4);
    check_eq("s3_trig_stall", 64'(stall), 64'd1);
    check_eq("s3_trig_cap", {trig_cap_hi, trig_cap_lo}, 64'h3333_0000_0000_0A00);
    for (int p = 0; p < 3; p++) begin
      single_step_rd = 1'b1;
      run_cycles(10);
    end
    check_eq("s3_ss_cnt", 64'(stat_ss_cnt), 64'd3);
    check_eq("s3_ss_cap", {ss_cap_hi, ss_cap_lo}, 64'h3333_0003_0000_0A03);
    check_eq("s3_ss_sb", 64'(ss_cap_sb), 64'h01);
    check_eq("s3_deliv", 64'(n_deliv - base), 64'd4);
    check_eq("s3_left", 64'(exp_q.size()), 64'd2);
    check_eq("s3_stall", 64'(stall), 64'd1);

    // S5: disable while stalled, concurrently with an arm strobe.
    trig_en = 0; arm_stb = 1;
    do_cycle();
    check_eq("s5_state", 64'(stat_state), 64'd0);
    check_eq("s5_stall", 64'(stall), 64'd0);
    trig_en = 1; rdy_mode = 0;
    drain(20, "s5");

    // S4: arm and a matching word in the same cycle; the next word triggers.
    ss_en = 0;
    push_word(64'h4444_0000_0000_00AA, 1, 1);
    arm();
    check_eq("s4_state", 64'(stat_state), 64'd1);
    check_eq("s4_trig_cnt", 64'(stat_trig_cnt), 64'd3);
    push_word(64'h4444_0000_0000_00BB, 1, 1);
    drain(10, "s4");
    check_eq("s4_trig_cap", {trig_cap_hi, trig_cap_lo}, 64'h4444_0000_0000_00BB);
    check_eq("s4_trig_cnt2", 64'(stat_trig_cnt), 64'd4);

    // S6: trigger count saturation.
    for (int i = 0; i < 256; i++) begin
      arm();
      push_word({$urandom, $urandom}, 1, 1);
      drain(10, "s6");
    end
    check_eq("s6_trig_cnt_sat", 64'(stat_trig_cnt), 64'd255);

    // S7: asynchronous reset while stalled releases the stream at once.
    ss_en = 1;
    arm();
    push_word(64'h7777_0000_0000_0001, 1, 0);
    push_word(64'h7777_0000_0000_0002, 0, 1);
    run_cycles(3);
    check_eq("s7_pre_stall", 64'(stall), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("s7_in_rdy", 64'(st_if.in_rdy), 64'd1);
    check_eq("s7_ds_vld", 64'(st_if.ds_vld), 64'(st_if.in_vld));
    check_outputs("s7_");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic against the model.
    rdy_mode = 1; gap_pct = 25;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        tlv_chk_en = 1'($urandom_range(0, 1));
        trig_tlv_type = 8'($urandom_range(0, 3));
        match_lo = $urandom; match_hi = $urandom;
        mask_lo = $urandom & 32'h0000_0303;
        mask_hi = 32'd0;
      end
      if (exp_q.size() < 4) begin
        int len;
        len = $urandom_range(1, 4);
        for (int w = 0; w < len; w++) begin
          logic [63:0] d;
          d = {$urandom, $urandom};
          if (w == 0) d[7:0] = 8'($urandom_range(0, 3));
          push_word(d, (w == 0), (w == len - 1));
        end
      end
      arm_stb = ($urandom_range(0, 29) == 0);
      single_step_rd = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 149) == 0) trig_en = ~trig_en;
      else if (!trig_en && $urandom_range(0, 9) == 0) trig_en = 1;
      if ($urandom_range(0, 79) == 0) ss_en = ~ss_en;
      do_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
